// File: rtl/bip_pkg.sv
// Shared definitions for the BIP memory system: widths, opcodes, FSM encoding.
package bip_pkg;

  localparam int NB_OPCODE   = 5;
  localparam int NB_OPERANDO = 11;
  localparam int NB_ADDR     = 11;
  localparam int RAM_WIDTH   = 16;
  localparam int PM_DEPTH    = 2048;
  localparam int DM_DEPTH    = 2048;
  localparam int NB_INSTR    = NB_OPCODE + NB_OPERANDO;

  localparam logic [NB_OPCODE-1:0] OP_HALT = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/bip_memory_system_if.sv
// Loader link and CPU memory port bundle of the BIP memory system.
interface bip_memory_system_if;
  import bip_pkg::*;

  // Loader handshake: a word transfers on a rising clock edge where i_ld_valid and o_ld_ready are both 1.
  logic                   i_ld_valid;
  logic [NB_INSTR-1:0]    i_ld_word;
  logic                   i_ld_last;
  logic                   o_ld_ready;
  logic                   i_restart;
  logic [NB_ADDR-1:0]     i_addr_pm;
  logic [NB_OPCODE-1:0]   o_opcode_pm;
  logic [NB_OPERANDO-1:0] o_operando_pm;
  logic                   i_wr_en;
  logic [RAM_WIDTH-1:0]   i_data;
  logic [RAM_WIDTH-1:0]   o_data;
  logic                   o_cpu_rst;
  logic                   o_halted;
  logic [31:0]            o_cycles;
  logic [1:0]             o_state;

  modport master (
    output i_ld_valid, i_ld_word, i_ld_last, i_restart, i_addr_pm, i_wr_en, i_data,
    input  o_ld_ready, o_opcode_pm, o_operando_pm, o_data, o_cpu_rst, o_halted,
           o_cycles, o_state
  );

  modport slave (
    input  i_ld_valid, i_ld_word, i_ld_last, i_restart, i_addr_pm, i_wr_en, i_data,
    output o_ld_ready, o_opcode_pm, o_operando_pm, o_data, o_cpu_rst, o_halted,
           o_cycles, o_state
  );

endinterface

// File: rtl/bip_loader.sv
// Program-loader write pointer: accepts one word per cycle while active and
// flags the final word (explicit last or program memory full, no wrap).
module bip_loader
  import bip_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               restart,
  input  logic               ld_valid,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               pm_we,
  output logic [NB_ADDR-1:0] pm_addr,
  output logic               done
);

  logic [NB_ADDR-1:0] ptr;
  logic               accept;

  assign ld_ready = active;
  // A restart in the same cycle wins and the offered word is dropped.
  assign accept   = active & ld_valid & ~restart;
  assign pm_we    = accept;
  assign pm_addr  = ptr;
  assign done     = accept & (ld_last | (ptr == NB_ADDR'(PM_DEPTH - 1)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (restart || done) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bip_memory_system.sv
// BIP program/data memory responder with streaming loader and HALT freeze.
// Optional RUN-cycle counter built when BIP_MEM_CYCLE_COUNT_EN is defined.
module bip_memory_system
  import bip_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  bip_memory_system_if.slave  bus
);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [NB_INSTR-1:0]    pm [PM_DEPTH];
  logic [RAM_WIDTH-1:0]   dm [DM_DEPTH];
  logic [NB_INSTR-1:0]    fetch_word;
  logic                   dm_in_range;
  logic                   dm_we;
  logic                   pm_we;
  logic [NB_ADDR-1:0]     pm_addr;
  logic                   ld_done;

  bip_loader u_loader (
    .clk      (i_clk),
    .rst      (i_rst),
    .active   (state == ST_LOAD),
    .restart  (bus.i_restart),
    .ld_valid (bus.i_ld_valid),
    .ld_last  (bus.i_ld_last),
    .ld_ready (bus.o_ld_ready),
    .pm_we    (pm_we),
    .pm_addr  (pm_addr),
    .done     (ld_done)
  );

  // Out-of-range PCs read as an all-zero word, i.e. HALT.
  always_comb begin
    fetch_word = '0;
    if (int'(bus.i_addr_pm) < PM_DEPTH) fetch_word = pm[bus.i_addr_pm];
  end

  assign bus.o_opcode_pm   = (state == ST_HALT) ? OP_HALT : fetch_word[NB_INSTR-1 -: NB_OPCODE];
  assign bus.o_operando_pm = fetch_word[NB_OPERANDO-1:0];

  assign dm_in_range = int'(bus.o_operando_pm) < DM_DEPTH;
  assign bus.o_data  = dm_in_range ? dm[bus.o_operando_pm] : '0;
  assign dm_we       = (state == ST_RUN) & bus.i_wr_en & dm_in_range;

  always_ff @(posedge i_clk) begin
    if (pm_we) pm[pm_addr] <= bus.i_ld_word;
    if (dm_we) dm[bus.o_operando_pm] <= bus.i_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (ld_done) state_nxt = ST_RUN;
      ST_RUN:  if (fetch_word[NB_INSTR-1 -: NB_OPCODE] == OP_HALT) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_LOAD;
    endcase
    if (bus.i_restart) state_nxt = ST_LOAD;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // CPU stays in reset only while loading; HALT keeps it running on the HALT loop.
  assign bus.o_cpu_rst = (state != ST_LOAD);
  assign bus.o_halted  = (state == ST_HALT);
  assign bus.o_state   = state;

`ifdef BIP_MEM_CYCLE_COUNT_EN
  logic [31:0] cycles;

  always_ff @(posedge i_clk) begin
    if (!i_rst || bus.i_restart) begin
      cycles <= '0;
    end else if (state == ST_RUN && cycles != 32'hFFFF_FFFF) begin
      cycles <= cycles + 32'd1;
    end
  end

  assign bus.o_cycles = cycles;
`else
  assign bus.o_cycles = '0;
`endif

endmodule

// File: tb/tb_bip_memory_system.sv
// Scoreboard bench for bip_memory_system against a mode/array reference model.
module tb_bip_memory_system;
  import bip_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bip_memory_system_if bus ();

  bip_memory_system dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  // Reference model: 0 = LOAD, 1 = RUN, 2 = HALT
  int          m_mode;
  int          m_ptr;
  logic [31:0] m_cyc;
  logic [15:0] ref_pm [PM_DEPTH];
  bit          pm_known [PM_DEPTH];
  logic [15:0] ref_dm [DM_DEPTH];
  bit          dm_known [DM_DEPTH];

  logic [W-1:0] exp_q [$];
  int           tag_q [$];
  int           checks = 0;
  int           errors = 0;

  function automatic string tag_name(input int t);
    case (t)
      0: return "ld_ready";
      1: return "cpu_rst";
      2: return "halted";
      3: return "opcode_pm";
      4: return "operando_pm";
      5: return "data";
      6: return "cycles";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int t, input logic [W-1:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  // Monitor: compares everything queued for the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (tag_q.size() > 0) begin
      int           t;
      logic [W-1:0] e;
      logic [W-1:0] a;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      case (t)
        0: a = W'(bus.o_ld_ready);
        1: a = W'(bus.o_cpu_rst);
        2: a = W'(bus.o_halted);
        3: a = W'(bus.o_opcode_pm);
        4: a = W'(bus.o_operando_pm);
        5: a = W'(bus.o_data);
        default: a = bus.o_cycles;
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s at %0t: got %0h expected %0h", tag_name(t), $time, a, e);
      end
    end
  end

  task automatic drive_idle();
    bus.i_ld_valid = 1'b0;
    bus.i_ld_word  = '0;
    bus.i_ld_last  = 1'b0;
    bus.i_restart  = 1'b0;
    bus.i_addr_pm  = '0;
    bus.i_wr_en    = 1'b0;
    bus.i_data     = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    m_mode = 0;
    m_ptr  = 0;
    m_cyc  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle of stimulus; expectations come from the model's pre-edge state.
  task automatic step(input bit valid, input logic [15:0] word, input bit last,
                      input bit restart, input logic [10:0] addr,
                      input bit wr, input logic [15:0] data);
    logic [15:0] fw;
    @(posedge clk);
    #1;
    bus.i_ld_valid = valid;
    bus.i_ld_word  = word;
    bus.i_ld_last  = last;
    bus.i_restart  = restart;
    bus.i_addr_pm  = addr;
    bus.i_wr_en    = wr;
    bus.i_data     = data;

    push(0, W'(m_mode == 0));
    push(1, W'(m_mode != 0));
    push(2, W'(m_mode == 2));
`ifdef BIP_MEM_CYCLE_COUNT_EN
    push(6, m_cyc);
`else
    push(6, '0);
`endif
    fw = ref_pm[addr];
    if (m_mode != 0 && pm_known[addr]) begin
      push(3, (m_mode == 2) ? W'(0) : W'(fw[15:11]));
      push(4, W'(fw[10:0]));
      if (dm_known[fw[10:0]]) push(5, W'(ref_dm[fw[10:0]]));
    end

    if (restart) begin
      m_mode = 0;
      m_ptr  = 0;
      m_cyc  = '0;
    end else if (m_mode == 0) begin
      if (valid) begin
        ref_pm[m_ptr]   = word;
        pm_known[m_ptr] = 1'b1;
        if (last || m_ptr == PM_DEPTH - 1) begin
          m_mode = 1;
          m_ptr  = 0;
        end else begin
          m_ptr++;
        end
      end
    end else if (m_mode == 1) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (wr) begin
        ref_dm[fw[10:0]]   = data;
        dm_known[fw[10:0]] = 1'b1;
      end
      if (fw[15:11] == 5'd0) m_mode = 2;
    end
  endtask

  task automatic ld(input logic [15:0] word, input bit last);
    step(1'b1, word, last, 1'b0, 11'd0, 1'b0, 16'd0);
  endtask

  task automatic cpu(input logic [10:0] addr, input bit wr, input logic [15:0] data);
    step(1'b0, 16'd0, 1'b0, 1'b0, addr, wr, data);
  endtask

  task automatic restart_pulse(input bit valid, input logic [10:0] addr);
    step(valid, 16'($urandom), 1'b0, 1'b1, addr, 1'b0, 16'd0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0]  op;
    logic [10:0] opnd;
    op   = 5'($urandom_range(1, 31));
    opnd = 11'($urandom);
    return {op, opnd};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < PM_DEPTH; i++) pm_known[i] = 1'b0;
    for (int i = 0; i < DM_DEPTH; i++) dm_known[i] = 1'b0;
    drive_idle();
    do_reset();

    // Reset state, then the three-word program LDI 5 / STO 7 / HALT.
    cpu(11'd0, 1'b0, 16'd0);
    ld({OP_LDI, 11'd5}, 1'b0);
    ld({OP_STO, 11'd7}, 1'b0);
    ld({OP_HALT, 11'd0}, 1'b1);

    // RUN: first fetch at PC 0, write-then-read on operand 7.
    cpu(11'd0, 1'b0, 16'd0);
    cpu(11'd1, 1'b1, 16'h1234);
    cpu(11'd1, 1'b1, 16'h00A5);
    cpu(11'd1, 1'b0, 16'd0);
    for (int i = 0; i < 12; i++)
      cpu(11'($urandom_range(0, 1)), 1'($urandom), 16'($urandom));

    // HALT at PC 2, then writes must be blocked and the image frozen.
    cpu(11'd2, 1'b0, 16'd0);
    for (int i = 0; i < 6; i++)
      cpu(11'($urandom_range(0, 2)), 1'b1, 16'($urandom));

    // Restart, then fill program memory without a last marker.
    restart_pulse(1'b0, 11'd0);
    for (int i = 0; i < PM_DEPTH; i++) ld(rand_instr(), 1'b0);

    // Restart in the first RUN cycle with a coincident loader word.
    restart_pulse(1'b1, 11'($urandom));
    cpu(11'd0, 1'b0, 16'd0);

    // Short random program: the dropped word must not have advanced the pointer.
    for (int i = 0; i < 8; i++)
      ld((i == 7 && $urandom_range(0, 1) == 1) ? 16'h0000 : rand_instr(), i == 7);
    for (int i = 0; i < 60; i++)
      cpu(11'($urandom_range(0, 15)), 1'($urandom), 16'($urandom));

    // Reset in mid-load keeps memory; reload a single HALT at address 0.
    restart_pulse(1'b0, 11'd0);
    ld({OP_ADDI, 11'd3}, 1'b0);
    ld({OP_SUBI, 11'd9}, 1'b0);
    do_reset();
    cpu(11'd0, 1'b0, 16'd0);
    ld({OP_HALT, 11'd0}, 1'b1);
    cpu(11'd1, 1'b0, 16'd0);
    cpu(11'd0, 1'b0, 16'd0);
    cpu(11'd0, 1'b1, 16'hBEEF);
    cpu(11'd1, 1'b0, 16'd0);

    repeat (3) @(posedge clk);
    checks++;
    if (tag_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", tag_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
